decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_pkg.sv | 56 +++++
 rtl/reg_file.sv | 57 +++++
 rtl/decode_stage.sv | 189 ++++++++++++++++++
 tb/tb_decode_stage.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// ---------------------------------------------------------------------------
// decode_pkg
// Shared constants for the decode stage: RV32 opcode values, the encodings
// driven on the decode control outputs, and the immediate-format selector.
// No ports (package).
// ---------------------------------------------------------------------------
package decode_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_MEM  = 2'b01,
    RES_PC4  = 2'b10
  } result_src_e;

  typedef enum logic [2:0] {
    MW_NONE = 3'b000,
    MW_SB   = 3'b001,
    MW_SH   = 3'b010,
    MW_SW   = 3'b011
  } mem_write_e;

  typedef enum logic [1:0] {
    JMP_NONE = 2'b00,
    JMP_JAL  = 2'b01,
    JMP_JALR = 2'b10
  } jump_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4
  } imm_type_e;

endpackage

// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file
// 32 x 32-bit register file, x0 hard-wired to zero.
// Ports:
//   clk, rst_n          rising-edge clock, async active-low reset (clears all)
//   we, waddr, wdata    synchronous write port (writes to x0 dropped)
//   raddr1, raddr2      asynchronous read addresses
//   rdata1, rdata2      read data (0 while rst_n is low)
// Configuration macro: DECODE_WB_BYPASS_EN -- when defined, a write in the
// same cycle as a read of the same register is forwarded to the read port.
// ---------------------------------------------------------------------------
module reg_file (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);

  logic [31:0] regs [32];
  logic        wr_valid;

  assign wr_valid = we && (waddr != 5'd0);

  // Storage: the whole array clears while reset is held, so writes during
  // reset are naturally lost; x0 is never written and stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'd0;
      end
    end else if (wr_valid) begin
      regs[waddr] <= wdata;
    end
  end

  // Read ports are forced to zero during reset so a forwarded write value
  // cannot leak out before the array is usable.
  always_comb begin
    rdata1 = 32'd0;
    rdata2 = 32'd0;
    if (rst_n) begin
`ifdef DECODE_WB_BYPASS_EN
      rdata1 = (wr_valid && (waddr == raddr1)) ? wdata : regs[raddr1];
      rdata2 = (wr_valid && (waddr == raddr2)) ? wdata : regs[raddr2];
`else
      rdata1 = regs[raddr1];
      rdata2 = regs[raddr2];
`endif
    end
  end

endmodule

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
// RV32 subset instruction decoder with register file read and immediate
// generation. Supports R-type, I-ALU, LB/LH/LW, SB/SH/SW, BEQ, JAL, JALR, LUI.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   InstrD_i, PCD_i, PCPlus4D_i       fetched instruction and its PCs
//   FlushD_i                          squash side-effect controls
//   RegWriteW_i, RdW_i, ResultW_i     writeback port into the register file
//   RegWriteD_o .. IllegalD_o         decoded controls
//   RD1D_o, RD2D_o, PCD_o, RdD_o,
//   ImmExtD_o, PCPlus4D_o             decoded data
// Configuration macro: DECODE_WB_BYPASS_EN (see reg_file).
// ---------------------------------------------------------------------------
module decode_stage
  import decode_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] InstrD_i,
  input  logic [31:0] PCD_i,
  input  logic [31:0] PCPlus4D_i,
  input  logic        FlushD_i,
  input  logic        RegWriteW_i,
  input  logic [4:0]  RdW_i,
  input  logic [31:0] ResultW_i,
  output logic        RegWriteD_o,
  output logic [1:0]  ResultSrcD_o,
  output logic [2:0]  MemWriteD_o,
  output logic [1:0]  JumpD_o,
  output logic        BranchD_o,
  output logic [2:0]  ALUControlD_o,
  output logic        ALUSrcD_o,
  output logic        IllegalD_o,
  output logic [31:0] RD1D_o,
  output logic [31:0] RD2D_o,
  output logic [31:0] PCD_o,
  output logic [4:0]  RdD_o,
  output logic [31:0] ImmExtD_o,
  output logic [31:0] PCPlus4D_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic [4:0] rs1;
  logic [4:0] rs2;

  logic        reg_write;
  logic [2:0]  mem_write;
  logic [1:0]  jump;
  logic        branch;
  logic        illegal;
  imm_type_e   imm_type;
  alu_ctrl_e   alu_ctrl;

  assign opcode    = InstrD_i[6:0];
  assign funct3    = InstrD_i[14:12];
  assign funct7_b5 = InstrD_i[30];
  assign rs2       = InstrD_i[24:20];
  // LUI's rs1 field is part of the immediate; reading x0 lets the ALU add 0.
  assign rs1       = (opcode == OP_LUI) ? 5'd0 : InstrD_i[19:15];

  assign RdD_o      = InstrD_i[11:7];
  assign PCD_o      = PCD_i;
  assign PCPlus4D_o = PCPlus4D_i;

  reg_file u_reg_file (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (RegWriteW_i),
    .waddr  (RdW_i),
    .wdata  (ResultW_i),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (RD1D_o),
    .rdata2 (RD2D_o)
  );

  // Shared funct3 -> ALU op map for R-type and I-ALU; sub only on R-type.
  function automatic alu_ctrl_e alu_from_funct3(input logic [2:0] f3,
                                                input logic       is_sub);
    case (f3)
      3'b000:  return is_sub ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLT;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // Main decoder: raw controls before flush/illegal squashing.
  always_comb begin
    reg_write    = 1'b0;
    mem_write    = MW_NONE;
    jump         = JMP_NONE;
    branch       = 1'b0;
    illegal      = 1'b0;
    ResultSrcD_o = RES_ALU;
    ALUSrcD_o    = 1'b0;
    alu_ctrl     = ALU_ADD;
    imm_type     = IMM_I;
    case (opcode)
      OP_RTYPE: begin
        reg_write = 1'b1;
        alu_ctrl  = alu_from_funct3(funct3, funct7_b5);
      end
      OP_IALU: begin
        reg_write = 1'b1;
        ALUSrcD_o = 1'b1;
        alu_ctrl  = alu_from_funct3(funct3, 1'b0);
      end
      OP_LOAD: begin
        reg_write    = 1'b1;
        ALUSrcD_o    = 1'b1;
        ResultSrcD_o = RES_MEM;
        illegal      = (funct3 > 3'b010);
      end
      OP_STORE: begin
        ALUSrcD_o = 1'b1;
        imm_type  = IMM_S;
        case (funct3)
          3'b000:  mem_write = MW_SB;
          3'b001:  mem_write = MW_SH;
          3'b010:  mem_write = MW_SW;
          default: illegal   = 1'b1;
        endcase
      end
      OP_BRANCH: begin
        imm_type = IMM_B;
        alu_ctrl = ALU_SUB;
        branch   = (funct3 == 3'b000);
        illegal  = (funct3 != 3'b000);
      end
      OP_JAL: begin
        reg_write    = 1'b1;
        jump         = JMP_JAL;
        ResultSrcD_o = RES_PC4;
        imm_type     = IMM_J;
      end
      OP_JALR: begin
        reg_write    = 1'b1;
        jump         = JMP_JALR;
        ResultSrcD_o = RES_PC4;
        ALUSrcD_o    = 1'b1;
      end
      OP_LUI: begin
        reg_write = 1'b1;
        ALUSrcD_o = 1'b1;
        imm_type  = IMM_U;
      end
      default: illegal = 1'b1;
    endcase
  end

  // A flushed slot is a bubble, not a fault, so it never raises IllegalD_o.
  always_comb begin
    IllegalD_o    = illegal && !FlushD_i;
    ALUControlD_o = alu_ctrl;
    RegWriteD_o   = reg_write;
    MemWriteD_o   = mem_write;
    JumpD_o       = jump;
    BranchD_o     = branch;
    if (illegal || FlushD_i) begin
      RegWriteD_o = 1'b0;
      MemWriteD_o = MW_NONE;
      JumpD_o     = JMP_NONE;
      BranchD_o   = 1'b0;
    end
  end

  // Immediate generation, sign-extended from bit 31 for every format.
  always_comb begin
    ImmExtD_o = {{20{InstrD_i[31]}}, InstrD_i[31:20]};
    case (imm_type)
      IMM_S: ImmExtD_o = {{20{InstrD_i[31]}}, InstrD_i[31:25], InstrD_i[11:7]};
      IMM_B: ImmExtD_o = {{20{InstrD_i[31]}}, InstrD_i[7], InstrD_i[30:25],
                          InstrD_i[11:8], 1'b0};
      IMM_J: ImmExtD_o = {{12{InstrD_i[31]}}, InstrD_i[19:12], InstrD_i[20],
                          InstrD_i[30:21], 1'b0};
      IMM_U: ImmExtD_o = {InstrD_i[31:12], 12'b0};
      default: ImmExtD_o = {{20{InstrD_i[31]}}, InstrD_i[31:20]};
    endcase
  end

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
// Directed self-checking bench for decode_stage. Honours DECODE_WB_BYPASS_EN
// for the same-cycle write/read expectation.
// ---------------------------------------------------------------------------
module tb_decode_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] InstrD_i;
  logic [31:0] PCD_i;
  logic [31:0] PCPlus4D_i;
  logic        FlushD_i;
  logic        RegWriteW_i;
  logic [4:0]  RdW_i;
  logic [31:0] ResultW_i;
  logic        RegWriteD_o;
  logic [1:0]  ResultSrcD_o;
  logic [2:0]  MemWriteD_o;
  logic [1:0]  JumpD_o;
  logic        BranchD_o;
  logic [2:0]  ALUControlD_o;
  logic        ALUSrcD_o;
  logic        IllegalD_o;
  logic [31:0] RD1D_o;
  logic [31:0] RD2D_o;
  logic [31:0] PCD_o;
  logic [4:0]  RdD_o;
  logic [31:0] ImmExtD_o;
  logic [31:0] PCPlus4D_o;

  int checks;
  int failures;

  decode_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .InstrD_i      (InstrD_i),
    .PCD_i         (PCD_i),
    .PCPlus4D_i    (PCPlus4D_i),
    .FlushD_i      (FlushD_i),
    .RegWriteW_i   (RegWriteW_i),
    .RdW_i         (RdW_i),
    .ResultW_i     (ResultW_i),
    .RegWriteD_o   (RegWriteD_o),
    .ResultSrcD_o  (ResultSrcD_o),
    .MemWriteD_o   (MemWriteD_o),
    .JumpD_o       (JumpD_o),
    .BranchD_o     (BranchD_o),
    .ALUControlD_o (ALUControlD_o),
    .ALUSrcD_o     (ALUSrcD_o),
    .IllegalD_o    (IllegalD_o),
    .RD1D_o        (RD1D_o),
    .RD2D_o        (RD2D_o),
    .PCD_o         (PCD_o),
    .RdD_o         (RdD_o),
    .ImmExtD_o     (ImmExtD_o),
    .PCPlus4D_o    (PCPlus4D_o)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one decode-side vector and a writeback request, 1 ns after an edge.
  task automatic applyStimulus(input logic [31:0] instr, input logic flush,
                               input logic we, input logic [4:0] rd,
                               input logic [31:0] res);
    InstrD_i    = instr;
    FlushD_i    = flush;
    RegWriteW_i = we;
    RdW_i       = rd;
    ResultW_i   = res;
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check32(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    applyStimulus(32'h00528333, 1'b0, 1'b1, 5'd5, 32'h0000BEEF);
    next_cycle();
    check32("rst_rd1", RD1D_o, 32'h0);
    check32("rst_rd2", RD2D_o, 32'h0);
    check32("rst_ctrl_regwrite", {31'b0, RegWriteD_o}, 32'h1);
    rst_n = 1'b1;
    applyStimulus(32'h00528333, 1'b0, 1'b0, 5'd0, 32'h0);
    check32("rst_write_ignored", RD1D_o, 32'h0);
  endtask

  task automatic test_add_passthrough();
    PCD_i      = 32'h0000_1000;
    PCPlus4D_i = 32'h0000_1004;
    applyStimulus(32'h00528333, 1'b0, 1'b1, 5'd5, 32'h0000_00AA);
    next_cycle();
    applyStimulus(32'h00528333, 1'b0, 1'b0, 5'd0, 32'h0);
    check32("add_rd1", RD1D_o, 32'hAA);
    check32("add_rd2", RD2D_o, 32'hAA);
    check32("add_aluctl", {29'b0, ALUControlD_o}, 32'h0);
    check32("add_regwrite", {31'b0, RegWriteD_o}, 32'h1);
    check32("add_rd", {27'b0, RdD_o}, 32'd6);
    check32("add_pc", PCD_o, 32'h0000_1000);
    check32("add_pc4", PCPlus4D_o, 32'h0000_1004);
    applyStimulus(32'h40528333, 1'b0, 1'b0, 5'd0, 32'h0);
    check32("sub_aluctl", {29'b0, ALUControlD_o}, 32'h1);
  endtask

  task automatic test_x0();
    applyStimulus(32'h00000333, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    check32("x0_during_write", RD1D_o, 32'h0);
    next_cycle();
    applyStimulus(32'h00000333, 1'b0, 1'b0, 5'd0, 32'h0);
    check32("x0_after_write", RD1D_o, 32'h0);
  endtask

  task automatic test_store();
    applyStimulus(32'hFE20AE23, 1'b0, 1'b0, 5'd0, 32'h0);
    check32("sw_memwrite", {29'b0, MemWriteD_o}, 32'h3);
    check32("sw_imm", ImmExtD_o, 32'hFFFF_FFFC);
    check32("sw_alusrc", {31'b0, ALUSrcD_o}, 32'h1);
    check32("sw_regwrite", {31'b0, RegWriteD_o}, 32'h0);
    // funct3=011 under the store opcode is not a supported width
    applyStimulus(32'hFE20BE23, 1'b0, 1'b0, 5'd0, 32'h0);
    check32("sd_illegal", {31'b0, IllegalD_o}, 32'h1);
    check32("sd_memwrite", {29'b0, MemWriteD_o}, 32'h0);
  endtask

  task automatic test_jal_flush();
    applyStimulus(32'h008000EF, 1'b0, 1'b0, 5'd0, 32'h0);
    check32("jal_jump", {30'b0, JumpD_o}, 32'h1);
    check32("jal_ressrc", {30'b0, ResultSrcD_o}, 32'h2);
    check32("jal_imm", ImmExtD_o, 32'h8);
    applyStimulus(32'h008000EF, 1'b1, 1'b0, 5'd0, 32'h0);
    check32("jal_flush_jump", {30'b0, JumpD_o}, 32'h0);
    check32("jal_flush_regwrite", {31'b0, RegWriteD_o}, 32'h0);
    check32("jal_flush_illegal", {31'b0, IllegalD_o}, 32'h0);
  endtask

  task automatic test_branch_load_lui();
    applyStimulus(32'h00528863, 1'b0, 1'b0, 5'd0, 32'h0);
    check32("beq_branch", {31'b0, BranchD_o}, 32'h1);
    check32("beq_imm", ImmExtD_o, 32'd16);
    check32("beq_aluctl", {29'b0, ALUControlD_o}, 32'h1);
    applyStimulus(32'h0082A483, 1'b0, 1'b0, 5'd0, 32'h0);
    check32("lw_ressrc", {30'b0, ResultSrcD_o}, 32'h1);
    check32("lw_imm", ImmExtD_o, 32'd8);
    check32("lw_rd1", RD1D_o, 32'hAA);
    // preload x8 so the forced-zero rs1 of LUI is observable
    applyStimulus(32'h00000013, 1'b0, 1'b1, 5'd8, 32'h0000_0055);
    next_cycle();
    applyStimulus(32'h123451B7, 1'b0, 1'b0, 5'd0, 32'h0);
    check32("lui_imm", ImmExtD_o, 32'h1234_5000);
    check32("lui_rd1", RD1D_o, 32'h0);
    check32("lui_alusrc", {31'b0, ALUSrcD_o}, 32'h1);
  endtask

  task automatic test_back_to_back();
    // add x8,x7,x0 while writing x7 in the same cycle
    applyStimulus(32'h00038433, 1'b0, 1'b1, 5'd7, 32'h0000_1234);
`ifdef DECODE_WB_BYPASS_EN
    check32("same_cycle_rd1", RD1D_o, 32'h0000_1234);
`else
    check32("same_cycle_rd1", RD1D_o, 32'h0);
`endif
    next_cycle();
    applyStimulus(32'h00038433, 1'b0, 1'b0, 5'd0, 32'h0);
    check32("next_cycle_rd1", RD1D_o, 32'h0000_1234);
  endtask

  task automatic test_illegal_midreset();
    applyStimulus(32'hFFFF_FFFF, 1'b0, 1'b0, 5'd0, 32'h0);
    check32("ill_flag", {31'b0, IllegalD_o}, 32'h1);
    check32("ill_side_effects",
            {24'b0, RegWriteD_o, MemWriteD_o, JumpD_o, BranchD_o}, 32'h0);
    applyStimulus(32'h00528333, 1'b0, 1'b0, 5'd0, 32'h0);
    rst_n = 1'b0;
    #1;
    check32("midrst_rd1", RD1D_o, 32'h0);
    rst_n = 1'b1;
    #1;
    check32("midrst_x5_cleared", RD1D_o, 32'h0);
    applyStimulus(32'h00038433, 1'b0, 1'b0, 5'd0, 32'h0);
    check32("midrst_x7_cleared", RD1D_o, 32'h0);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    PCD_i       = 32'h0;
    PCPlus4D_i  = 32'h4;
    applyStimulus(32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    test_reset();
    test_add_passthrough();
    test_x0();
    test_store();
    test_jal_flush();
    test_branch_load_lui();
    test_back_to_back();
    test_illegal_midreset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
